// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter : arbitrates fetch and load/store ports onto one memory port
// Revision 1.0
// ============================================================================
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_wlen,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [1:0]  mem_write_length,
  input  logic [31:0] mem_read_data
);

  localparam int               CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]       C_LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [1:0]       len_q, len_d;
  logic             owner_q, owner_d;  // 1 = data port owns the transaction
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             w_arb;
  logic             w_fetch_wins;
  logic             w_d_grant;
  logic             w_if_grant;
  logic [31:0]      w_resp_data;

  always_comb begin
    w_arb        = (state_q == S_IDLE) && reset_n;
    w_fetch_wins = if_req && (starve_q == C_LIMIT);
    w_d_grant    = w_arb && d_req && !w_fetch_wins;
    w_if_grant   = w_arb && if_req && !w_d_grant;
    w_resp_data  = we_q ? 32'd0 : mem_read_data;

    if_ready         = w_if_grant;
    d_ready          = w_d_grant;
    mem_address      = addr_q;
    mem_wr_data      = wdata_q;
    mem_write_length = len_q;
    mem_wr_enable    = (state_q == S_ISSUE) && we_q && reset_n;
    if_rvalid        = (state_q == S_RESP) && !owner_q && reset_n;
    d_rvalid         = (state_q == S_RESP) && owner_q && reset_n;
    // Memory data arrives in the response cycle, so it bypasses the hold register.
    if_rdata         = if_rvalid ? w_resp_data : if_rdata_q;
    d_rdata          = d_rvalid ? w_resp_data : d_rdata_q;
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    len_d      = len_q;
    owner_d    = owner_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_d_grant) begin
          state_d  = S_ISSUE;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          len_d    = d_wlen;
          owner_d  = 1'b1;
          if (if_req) begin
            starve_d = (starve_q == C_LIMIT) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (w_if_grant) begin
          state_d  = S_ISSUE;
          addr_d   = if_addr;
          wdata_d  = 32'd0;
          we_d     = 1'b0;
          len_d    = C_LEN_WORD;
          owner_d  = 1'b0;
          starve_d = '0;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (if_rvalid) if_rdata_d = w_resp_data;
    if (d_rvalid)  d_rdata_d  = w_resp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      len_q      <= 2'd0;
      owner_q    <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      len_q      <= len_d;
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_memory_arbiter : randomized scoreboard bench for memory_arbiter
// Revision 1.0
// ============================================================================
module tb_memory_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_wlen = '0;
  logic        if_ready, if_rvalid, d_ready, d_rvalid, mem_wr_enable;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_wr_data;
  logic [1:0]  mem_write_length;
  logic [31:0] mem_read_data = '0;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wlen(d_wlen), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data),
    .mem_wr_enable(mem_wr_enable), .mem_write_length(mem_write_length),
    .mem_read_data(mem_read_data)
  );

  // Memory environment (low 8 address bits, little-endian) and the model's own copy.
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];
  bit         env_init = 1'b0;

  function automatic int nbytes(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] env_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {env_mem[b + 8'd3], env_mem[b + 8'd2], env_mem[b + 8'd1], env_mem[b]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  always @(posedge clk) begin
    if (!env_init) begin
      env_mem  <= ref_mem;
      env_init <= 1'b1;
    end else if (mem_wr_enable) begin
      for (int i = 0; i < 4; i++)
        if (i < nbytes(mem_write_length))
          env_mem[mem_address[7:0] + 8'(i)] <= mem_wr_data[8*i +: 8];
    end
    mem_read_data <= env_word(mem_address);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int cyc; logic [31:0] data; } resp_t;
  typedef struct { int cyc; logic st; logic [31:0] addr; logic [31:0] wdata; logic [1:0] len; } iss_t;

  resp_t if_q[$];
  resp_t d_q[$];
  iss_t  iss_q[$];

  // Requester state and reference model state
  bit          rst_v = 1'b0;
  bit          pend_f = 1'b0, pend_d = 1'b0;
  logic [31:0] pf_addr = '0, pd_addr = '0, pd_wdata = '0;
  logic        pd_we = 1'b0;
  logic [1:0]  pd_wlen = '0;
  int          m_busy = 0, m_starve = 0;
  bit          m_st_valid = 1'b0;
  logic [31:0] m_st_addr, m_st_data;
  logic [1:0]  m_st_len;
  bit          log_en = 1'b0;
  bit          grant_log[$];
  bit          mon_en = 1'b0;

  task automatic step();
    bit idle, exp_d, exp_f;
    @(negedge clk);
    reset_n = rst_v;
    if_req  = pend_f;
    if_addr = pend_f ? pf_addr : $urandom;
    d_req   = pend_d;
    d_we    = pend_d ? pd_we : 1'($urandom);
    d_addr  = pend_d ? pd_addr : $urandom;
    d_wdata = pend_d ? pd_wdata : $urandom;
    d_wlen  = pend_d ? pd_wlen : 2'($urandom);
    #4;
    idle  = (m_busy == 0) && rst_v;
    exp_d = idle && pend_d && !(pend_f && m_starve == STARVE_LIMIT);
    exp_f = idle && pend_f && !exp_d;
    chk(if_ready === exp_f && d_ready === exp_d, "grant {if_ready,d_ready}",
        32'({if_ready, d_ready}), 32'({exp_f, exp_d}));
    if (m_busy == 2 && m_st_valid) begin
      if (rst_v)
        for (int i = 0; i < nbytes(m_st_len); i++)
          ref_mem[m_st_addr[7:0] + 8'(i)] = m_st_data[8*i +: 8];
      m_st_valid = 1'b0;
    end
    if (m_busy > 0) m_busy--;
    if (!rst_v) begin
      m_busy = 0; m_starve = 0; m_st_valid = 1'b0;
      if_q.delete(); d_q.delete(); iss_q.delete();
    end else if (exp_d) begin
      iss_q.push_back('{cyc + 1, pd_we, pd_addr, pd_wdata, pd_wlen});
      if (pd_we) begin
        m_st_valid = 1'b1; m_st_addr = pd_addr; m_st_data = pd_wdata; m_st_len = pd_wlen;
        d_q.push_back('{cyc + 2, 32'd0});
      end else begin
        d_q.push_back('{cyc + 2, ref_word(pd_addr)});
      end
      m_starve = pend_f ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
      m_busy = 2;
      pend_d = 1'b0;
      if (log_en) grant_log.push_back(1'b0);
    end else if (exp_f) begin
      iss_q.push_back('{cyc + 1, 1'b0, pf_addr, 32'd0, 2'd2});
      if_q.push_back('{cyc + 2, ref_word(pf_addr)});
      m_starve = 0;
      m_busy = 2;
      pend_f = 1'b0;
      if (log_en) grant_log.push_back(1'b1);
    end
  endtask

  // Monitor: compares memory-side and response-side activity against the scoreboard.
  logic [31:0] last_if = '0, last_d = '0;
  initial begin
    iss_t  ie;
    resp_t re;
    bit    ev;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
          ie = iss_q.pop_front();
          chk(mem_wr_enable === (ie.st && reset_n), "mem_wr_enable", 32'(mem_wr_enable), 32'(ie.st && reset_n));
          chk(mem_address === ie.addr, "mem_address", mem_address, ie.addr);
          chk(mem_write_length === ie.len, "mem_write_length", 32'(mem_write_length), 32'(ie.len));
          if (ie.st) chk(mem_wr_data === ie.wdata, "mem_wr_data", mem_wr_data, ie.wdata);
        end else begin
          chk(mem_wr_enable === 1'b0, "mem_wr_enable idle", 32'(mem_wr_enable), 32'd0);
        end

        ev = 1'b0;
        if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
          re = if_q.pop_front();
          ev = reset_n;
        end
        chk(if_rvalid === ev, "if_rvalid", 32'(if_rvalid), 32'(ev));
        if (ev) begin
          chk(if_rdata === re.data, "if_rdata", if_rdata, re.data);
          last_if = re.data;
        end else begin
          chk(if_rdata === last_if, "if_rdata hold", if_rdata, last_if);
        end

        ev = 1'b0;
        if (d_q.size() > 0 && d_q[0].cyc == cyc) begin
          re = d_q.pop_front();
          ev = reset_n;
        end
        chk(d_rvalid === ev, "d_rvalid", 32'(d_rvalid), 32'(ev));
        if (ev) begin
          chk(d_rdata === re.data, "d_rdata", d_rdata, re.data);
          last_d = re.data;
        end else begin
          chk(d_rdata === last_d, "d_rdata hold", d_rdata, last_d);
        end

        if (!reset_n) begin
          last_if = '0;
          last_d  = '0;
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while ((pend_f || pend_d) && n < 40) begin
      step();
      n++;
    end
    chk(!(pend_f || pend_d), "accept timeout", 32'({pend_f, pend_d}), 32'd0);
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] l);
    pend_d = 1'b1; pd_we = we; pd_addr = a; pd_wdata = wd; pd_wlen = l;
  endtask

  initial begin
    bit exp_pat [10];
    int n;
    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'h00500093;

    // Reset state
    rst_v = 1'b0;
    repeat (3) step();
    chk(mem_address === 32'd0, "reset mem_address", mem_address, 32'd0);
    chk(mem_wr_data === 32'd0, "reset mem_wr_data", mem_wr_data, 32'd0);
    chk(mem_write_length === 2'd0, "reset mem_write_length", 32'(mem_write_length), 32'd0);
    chk(if_rdata === 32'd0 && d_rdata === 32'd0, "reset rdata", if_rdata | d_rdata, 32'd0);
    mon_en = 1'b1;
    rst_v  = 1'b1;

    // Fetch only
    pend_f = 1'b1; pf_addr = 32'h10;
    wait_accept(); drain();

    // Store then load
    set_d(1'b1, 32'h20, 32'hDEADBEEF, 2'd2);
    wait_accept(); drain();
    set_d(1'b0, 32'h20, 32'h0, 2'd2);
    wait_accept(); drain();

    // Byte store followed by a fetch of the same word
    set_d(1'b1, 32'h31, 32'h000000A5, 2'd0);
    wait_accept(); drain();
    pend_f = 1'b1; pf_addr = 32'h30;
    wait_accept(); drain();

    // Data request pulsed during the response cycle
    set_d(1'b0, 32'h40, 32'h0, 2'd2);
    wait_accept();
    step();
    set_d(1'b0, 32'h44, 32'h0, 2'd2);
    step();
    pend_d = 1'b0;
    drain();

    // Reset during the issue cycle of a store; a load waits across the reset
    set_d(1'b1, 32'h50, 32'h12345678, 2'd2);
    wait_accept();
    rst_v = 1'b0;
    set_d(1'b0, 32'h50, 32'h0, 2'd2);
    step(); step();
    rst_v = 1'b1;
    step();
    chk(!pend_d, "accept after reset release", 32'(pend_d), 32'd0);
    drain();

    // Contention from a clean starvation counter
    rst_v = 1'b0; step(); step(); rst_v = 1'b1;
    grant_log.delete();
    log_en = 1'b1;
    n = 0;
    while (grant_log.size() < 10 && n < 80) begin
      if (!pend_f) begin pend_f = 1'b1; pf_addr = {$urandom_range(0, 63), 2'b00}; end
      if (!pend_d) set_d(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 2)));
      step();
      n++;
    end
    log_en = 1'b0;
    for (int i = 0; i < 10; i++)
      chk(i < grant_log.size() && grant_log[i] == exp_pat[i], "contention order (1=fetch)",
          (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFFFFFF, 32'(exp_pat[i]));
    wait_accept(); drain();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      if (!pend_f && $urandom_range(0, 2) == 0) begin
        pend_f = 1'b1; pf_addr = $urandom;
      end
      if (!pend_d && $urandom_range(0, 1) == 0)
        set_d(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 2)));
      rst_v = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_v = 1'b1;
    wait_accept(); drain();
    chk(if_q.size() == 0 && d_q.size() == 0 && iss_q.size() == 0, "outstanding responses",
        32'(if_q.size() + d_q.size() + iss_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
